// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
//
// Purpose:
//   Decouples stores from the single data-memory port. Stores are queued in a
//   small circular FIFO and written back to memory in the cycles when no load
//   is using the port. Loads take priority over draining, with two limits:
//   a full buffer facing a new store forces a drain, and a 3-bit starvation
//   counter forces a drain after seven consecutive cycles of loads winning
//   over a non-empty buffer.
//
// Configuration macro:
//   STORE_BUF_FWD_EN - when defined, a load whose address matches buffered
//                      stores is granted immediately and returns the youngest
//                      matching store's data. When undefined, such a load is
//                      stalled until every matching entry has drained, and
//                      is then served from memory.
//
// Ports:
//   clk            in   single clock, all state updates on posedge
//   rst_n          in   synchronous active-low reset
//   st_valid       in   store request
//   st_addr        in   store word address   [ADDR_W]
//   st_data        in   store data           [DATA_W]
//   st_ready       out  store accepted this cycle
//   ld_valid       in   load request
//   ld_addr        in   load word address    [ADDR_W]
//   ld_ready       out  load granted this cycle
//   ld_data        out  load data, valid in the grant cycle [DATA_W]
//   dm_address     out  data-memory address  [ADDR_W]
//   dm_write_data  out  data-memory write data [DATA_W]
//   dm_mem_read    out  data-memory read strobe
//   dm_mem_write   out  data-memory write strobe
//   dm_read_data   in   combinational data-memory read result [DATA_W]
//   empty          out  no buffered stores
// ---------------------------------------------------------------------------
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st_valid,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              st_ready,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_ready,
    output logic [DATA_W-1:0] ld_data,
    output logic [ADDR_W-1:0] dm_address,
    output logic [DATA_W-1:0] dm_write_data,
    output logic              dm_mem_read,
    output logic              dm_mem_write,
    input  logic [DATA_W-1:0] dm_read_data,
    output logic              empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [2:0]       STARV_MAX  = 3'd7;

    // Entry storage. Contents are never reset; only the pointers and the
    // occupancy count decide which entries are live.
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [2:0]       starv_q,  starv_d;

    logic buf_empty;
    logic buf_full;
    logic forced_drain;
    logic hazard;
    logic ld_grant;
    logic drain;
    logic push;

    logic             match_any;
    logic [PTR_W-1:0] idx;
`ifdef STORE_BUF_FWD_EN
    logic [DATA_W-1:0] fwd_data;
`endif

    // Walk the live entries from oldest to youngest. Each later hit
    // overwrites the earlier one, so the forwarded data ends up being the
    // youngest matching store.
    always_comb begin
        match_any = 1'b0;
        idx       = rd_ptr_q;
`ifdef STORE_BUF_FWD_EN
        fwd_data  = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && (addr_q[idx] == ld_addr)) begin
                match_any = 1'b1;
`ifdef STORE_BUF_FWD_EN
                fwd_data  = data_q[idx];
`endif
            end
        end
    end

    // With forwarding, a matching load is simply served from the buffer.
    // Without it, the load must wait for the matching stores to reach memory.
`ifdef STORE_BUF_FWD_EN
    assign hazard = 1'b0;
`else
    assign hazard = match_any;
`endif

    // Port arbitration and data-memory drive. Loads win the port unless a
    // drain is being forced. Drain is held off while reset is asserted so
    // a reset landing on a drain cycle never reaches memory.
    always_comb begin
        buf_empty     = (count_q == '0);
        buf_full      = (count_q == FULL_COUNT);
        forced_drain  = (buf_full && st_valid) ||
                        ((starv_q == STARV_MAX) && !buf_empty);
        ld_grant      = ld_valid && !forced_drain && !hazard;
        drain         = rst_n && !buf_empty && !ld_grant;
        push          = st_valid && !buf_full;

        st_ready      = !buf_full;
        empty         = buf_empty;
        ld_ready      = ld_grant;
        ld_data       = '0;
        dm_address    = '0;
        dm_write_data = '0;
        dm_mem_read   = 1'b0;
        dm_mem_write  = 1'b0;

        if (ld_grant) begin
            dm_address  = ld_addr;
            dm_mem_read = 1'b1;
`ifdef STORE_BUF_FWD_EN
            ld_data     = match_any ? fwd_data : dm_read_data;
`else
            ld_data     = dm_read_data;
`endif
        end else if (drain) begin
            dm_address    = addr_q[rd_ptr_q];
            dm_write_data = data_q[rd_ptr_q];
            dm_mem_write  = 1'b1;
        end
    end

    // Next-state for pointers, occupancy and the starvation counter. The
    // pointers are exactly log2(DEPTH) bits wide, so they wrap from DEPTH-1
    // to 0 on their own.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        starv_d  = starv_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (drain) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        unique case ({push, drain})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // The counter measures how long loads have kept a non-empty buffer
        // from draining; any drain or an empty buffer restarts it.
        if (buf_empty || drain) begin
            starv_d = '0;
        end else if (ld_grant) begin
            starv_d = starv_q + 3'd1;
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starv_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starv_q  <= starv_d;
        end
    end

    // Entry write on an accepted store.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            addr_q[wr_ptr_q] <= st_addr;
            data_q[wr_ptr_q] <= st_data;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// ---------------------------------------------------------------------------
// tb_store_buffer
//
// Purpose:
//   Self-checking bench for store_buffer. A queue-based reference model of the
//   buffer plus a reference memory predicts every output each cycle; directed
//   sequences pin the model with hand-computed literals, followed by a long
//   randomized run. Define STORE_BUF_FWD_EN to check the forwarding build.
// ---------------------------------------------------------------------------
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstN;
    logic        stValid;
    logic [15:0] stAddr;
    logic [15:0] stData;
    logic        stReady;
    logic        ldValid;
    logic [15:0] ldAddr;
    logic        ldReady;
    logic [15:0] ldData;
    logic [15:0] dmAddress;
    logic [15:0] dmWriteData;
    logic        dmMemRead;
    logic        dmMemWrite;
    logic [15:0] dmReadData;
    logic        empty;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(16), .DATA_W(16)) dut (
        .clk          (clk),
        .rst_n        (rstN),
        .st_valid     (stValid),
        .st_addr      (stAddr),
        .st_data      (stData),
        .st_ready     (stReady),
        .ld_valid     (ldValid),
        .ld_addr      (ldAddr),
        .ld_ready     (ldReady),
        .ld_data      (ldData),
        .dm_address   (dmAddress),
        .dm_write_data(dmWriteData),
        .dm_mem_read  (dmMemRead),
        .dm_mem_write (dmMemWrite),
        .dm_read_data (dmReadData),
        .empty        (empty)
    );

    // Data memory seen by the DUT, and the model's own copy of what memory
    // should hold. Only addresses below 256 are ever used.
    logic [15:0] tbMem  [0:255];
    logic [15:0] refMem [0:255];

    assign dmReadData = tbMem[dmAddress[7:0]];

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } entry_t;

    entry_t      modelQ[$];
    int          starv;
    bit          modelReady = 1'b0;
    bit          expPush;
    bit          expDrain;
    bit          expGrant;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] wrLogAddr[$];
    logic [15:0] wrLogData[$];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model prediction and per-cycle comparison, on the falling
    // edge while inputs are stable.
    always @(negedge clk) begin
        int          n;
        bit          full;
        bit          forced;
        bit          hazard;
        bit          fwdHit;
        logic [15:0] fwdData;
        logic [15:0] expLd;
        logic [15:0] expAddr;
        logic [15:0] expWdata;
        bit          expRd;
        bit          expWr;

        n       = modelQ.size();
        full    = (n == DEPTH);
        forced  = (full && stValid) || (starv >= 7 && n > 0);
        fwdHit  = 1'b0;
        fwdData = '0;
        foreach (modelQ[i]) begin
            if (modelQ[i].addr == ldAddr) begin
                fwdHit  = 1'b1;
                fwdData = modelQ[i].data;
            end
        end
`ifdef STORE_BUF_FWD_EN
        hazard = 1'b0;
`else
        hazard = fwdHit;
        fwdHit = 1'b0;
`endif
        expGrant = ldValid && !forced && !hazard;
        expDrain = (rstN === 1'b1) && n > 0 && !expGrant;
        expPush  = stValid && !full;

        expLd    = '0;
        expAddr  = '0;
        expWdata = '0;
        expRd    = 1'b0;
        expWr    = 1'b0;
        if (expGrant) begin
            expAddr = ldAddr;
            expRd   = 1'b1;
            expLd   = fwdHit ? fwdData : refMem[ldAddr[7:0]];
        end else if (expDrain) begin
            expAddr  = modelQ[0].addr;
            expWdata = modelQ[0].data;
            expWr    = 1'b1;
        end

        if (rstN === 1'b1 && modelReady) begin
            checkOutput("st_ready", stReady, !full);
            checkOutput("empty", empty, n == 0);
            checkOutput("ld_ready", ldReady, expGrant);
            checkOutput("ld_data", ldData, expLd);
            checkOutput("dm_address", dmAddress, expAddr);
            checkOutput("dm_write_data", dmWriteData, expWdata);
            checkOutput("dm_mem_read", dmMemRead, expRd);
            checkOutput("dm_mem_write", dmMemWrite, expWr);
            if (dmMemWrite === 1'b1) begin
                wrLogAddr.push_back(dmAddress);
                wrLogData.push_back(dmWriteData);
            end
        end
    end

    // Model state update and memory write on the rising edge.
    always @(posedge clk) begin
        int n0;
        if (rstN !== 1'b1) begin
            modelQ.delete();
            starv      = 0;
            modelReady = 1'b1;
        end else if (modelReady) begin
            n0 = modelQ.size();
            if (expDrain) begin
                refMem[modelQ[0].addr[7:0]] = modelQ[0].data;
                void'(modelQ.pop_front());
            end
            if (expPush) begin
                modelQ.push_back('{addr: stAddr, data: stData});
            end
            if (n0 == 0 || expDrain) begin
                starv = 0;
            end else if (expGrant) begin
                starv++;
            end
        end
        if (rstN === 1'b1 && dmMemWrite === 1'b1) begin
            tbMem[dmAddress[7:0]] <= dmWriteData;
        end
    end

    // Drive one cycle of inputs just after the rising edge, then return on
    // the falling edge so outputs can be sampled.
    task automatic applyStimulus(input bit r, input bit sv, input logic [15:0] sa,
                                 input logic [15:0] sd, input bit lv,
                                 input logic [15:0] la);
        @(posedge clk);
        #1;
        rstN    = r;
        stValid = sv;
        stAddr  = sa;
        stData  = sd;
        ldValid = lv;
        ldAddr  = la;
        @(negedge clk);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        end
    endtask

    initial begin
        logic [9:0] grantTrace;

        for (int i = 0; i < 256; i++) begin
            tbMem[i]  = 16'h5A00 ^ 16'(i);
            refMem[i] = 16'h5A00 ^ 16'(i);
        end
        rstN    = 1'b0;
        stValid = 1'b0;
        stAddr  = '0;
        stData  = '0;
        ldValid = 1'b0;
        ldAddr  = '0;

        // Reset and post-reset state.
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        applyStimulus(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        checkOutput("reset st_ready", stReady, 1'b1);
        checkOutput("reset empty", empty, 1'b1);
        checkOutput("reset dm_mem_write", dmMemWrite, 1'b0);
        checkOutput("reset dm_mem_read", dmMemRead, 1'b0);

        // Single store drains on the next cycle.
        applyStimulus(1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0);
        applyStimulus(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        checkOutput("single drain write", dmMemWrite, 1'b1);
        checkOutput("single drain addr", dmAddress, 16'h0010);
        checkOutput("single drain data", dmWriteData, 16'hBEEF);
        applyStimulus(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        checkOutput("single drain empty", empty, 1'b1);
        checkOutput("single drain mem", tbMem[8'h10], 16'hBEEF);

        // Fill with loads holding the port, then a 5th store forces a drain.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 16'h0040 + 16'(i), 16'h4000 + 16'(i), 1'b1, 16'h0050);
            checkOutput("fill ld_ready", ldReady, 1'b1);
        end
        applyStimulus(1'b1, 1'b1, 16'h0044, 16'h4444, 1'b1, 16'h0050);
        checkOutput("full st_ready", stReady, 1'b0);
        checkOutput("full ld_ready", ldReady, 1'b0);
        checkOutput("full forced write", dmMemWrite, 1'b1);
        checkOutput("full forced addr", dmAddress, 16'h0040);
        idleCycles(5);
        checkOutput("full drained empty", empty, 1'b1);

        // Two stores to one address, then a load of it.
        applyStimulus(1'b1, 1'b1, 16'h0020, 16'h1111, 1'b1, 16'h0030);
        applyStimulus(1'b1, 1'b1, 16'h0020, 16'h2222, 1'b1, 16'h0030);
`ifdef STORE_BUF_FWD_EN
        applyStimulus(1'b1, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0020);
        checkOutput("fwd ld_ready", ldReady, 1'b1);
        checkOutput("fwd ld_data", ldData, 16'h2222);
        checkOutput("fwd dm_mem_read", dmMemRead, 1'b1);
`else
        applyStimulus(1'b1, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0020);
        checkOutput("hazard stall 1", ldReady, 1'b0);
        checkOutput("hazard drain 1", dmWriteData, 16'h1111);
        applyStimulus(1'b1, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0020);
        checkOutput("hazard stall 2", ldReady, 1'b0);
        checkOutput("hazard drain 2", dmWriteData, 16'h2222);
        applyStimulus(1'b1, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0020);
        checkOutput("hazard grant", ldReady, 1'b1);
        checkOutput("hazard ld_data", ldData, 16'h2222);
`endif
        idleCycles(4);

        // Starvation: seven grants, forced drain on the eighth, then grants.
        applyStimulus(1'b1, 1'b1, 16'h0060, 16'h1234, 1'b0, 16'h0);
        grantTrace = '0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0030);
            grantTrace[i] = ldReady;
            if (i == 7) begin
                checkOutput("starve forced write", dmMemWrite, 1'b1);
            end
        end
        checkOutput("starve grant pattern", grantTrace, 10'b1101111111);

        // Wrap-around: ten stores interleaved with drains, FIFO order.
        idleCycles(2);
        wrLogAddr.delete();
        wrLogData.delete();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b1, 16'(i), 16'hA000 + 16'(i), 1'b0, 16'h0);
        end
        idleCycles(2);
        checkOutput("wrap write count", wrLogAddr.size(), 10);
        for (int i = 0; i < 10 && i < wrLogAddr.size(); i++) begin
            checkOutput("wrap write addr", wrLogAddr[i], 16'(i));
            checkOutput("wrap write data", wrLogData[i], 16'hA000 + 16'(i));
        end

        // Reset with three entries buffered discards them.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 16'h0080 + 16'(i), 16'hC000 + 16'(i), 1'b1, 16'h0070);
        end
        checkOutput("pre-reset empty", empty, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        applyStimulus(1'b1, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0070);
        checkOutput("post-reset empty", empty, 1'b1);
        checkOutput("post-reset st_ready", stReady, 1'b1);
        checkOutput("post-reset dm_mem_write", dmMemWrite, 1'b0);
        checkOutput("post-reset ld_ready", ldReady, 1'b1);
        checkOutput("post-reset no write", tbMem[8'h80], 16'h5A80);

        // Randomized run with phases of varying load pressure.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int ldPct;
            ldPct = ((cyc / 250) % 3 == 0) ? 30 : (((cyc / 250) % 3 == 1) ? 70 : 95);
            applyStimulus($urandom_range(0, 299) != 0,
                          $urandom_range(0, 99) < 55,
                          16'($urandom_range(0, 15)),
                          16'($urandom),
                          $urandom_range(0, 99) < ldPct,
                          16'($urandom_range(0, 15)));
        end
        idleCycles(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, buffer entries (power of two, 2..16).
REQ-002 SHALL have parameter ADDR_W, default 16, word address width.
REQ-003 SHALL have parameter DATA_W, default 16, data width.
REQ-004 SHALL have port clk  in  1  single clock, all state on posedge; one clock, reset synchronous and active-low.
REQ-005 SHALL have port rst_n  in  1  synchronous active-low reset.
REQ-006 SHALL have port st_valid  in  1  store request from EX/MEM.
REQ-007 SHALL have ports st_addr  in  ADDR_W and st_data  in  DATA_W  store address/data.
REQ-008 SHALL have port st_ready  out  1  store accepted this cycle.
REQ-009 SHALL have ports ld_valid  in  1 and ld_addr  in  ADDR_W  load request.
REQ-010 SHALL have ports ld_ready  out  1 and ld_data  out  DATA_W  load granted, with data valid in the same cycle.
REQ-011 SHALL have ports dm_address  out  ADDR_W, dm_write_data  out  DATA_W, dm_mem_read  out  1, dm_mem_write  out  1  data-memory port.
REQ-012 SHALL have port dm_read_data  in  DATA_W  combinational data-memory read result.
REQ-013 SHALL have port empty  out  1  no buffered stores (fence/drain indicator).

Function
REQ-014 SHALL hold stores in a circular FIFO: wr_ptr, rd_ptr, count of width log2(DEPTH)+1; pointers wrap DEPTH-1 -> 0.
REQ-015 SHALL assert st_ready = (count < DEPTH); push on st_valid && st_ready at posedge; no push when full, even if a drain occurs that cycle.
REQ-016 SHALL grant a load (ld_ready=1) when ld_valid, no forced drain (REQ-020), and no blocking hazard (REQ-026); on grant, drive dm_address=ld_addr and dm_mem_read=1.
REQ-017 SHALL return ld_data = dm_read_data on grant with no address match; latency zero cycles.
REQ-018 SHALL drain the oldest entry when the buffer is non-empty and no load is granted: dm_address/dm_write_data = head entry, dm_mem_write=1; pop at the same posedge.
REQ-019 SHALL keep count unchanged on simultaneous push and pop; never assert dm_mem_read and dm_mem_write together.
REQ-020 SHALL keep a 3-bit starvation counter: increments each cycle the buffer is non-empty and a load takes the port; clears on any drain or when empty; at value 7, a forced drain occurs next cycle (ld_ready=0, drain executes, counter clears).
REQ-021 SHALL drive ld_ready=0 and drain when count == DEPTH and st_valid is high (full-buffer forced drain).
REQ-022 SHALL drive empty = (count == 0).
REQ-023 SHALL drive dm_* outputs to 0 and ld_data to 0 in cycles with neither load grant nor drain.

Reset
REQ-024 SHALL, while rst_n==0 at posedge, clear count, wr_ptr, rd_ptr and starvation counter; buffered entries are discarded and entry contents need not be cleared.
REQ-025 SHALL present outputs after reset: st_ready=1, empty=1, dm_mem_write=0, dm_mem_read=0, ld_ready=ld_valid; a reset mid-drain cancels the pending pop with no further write.

Configuration
REQ-026 SHALL compile in store-to-load forwarding when macro STORE_BUF_FWD_EN is defined: a granted load matching buffered entries returns the youngest matching entry's data on ld_data; dm_mem_read is still asserted.
REQ-027 SHALL, without STORE_BUF_FWD_EN, hold ld_ready=0 while any buffered entry matches ld_addr; draining continues until no entry matches, then the load is granted from memory.

Verification
REQ-028 SHALL cover: reset, then st 0x0010<-0xBEEF with no loads -> next cycle dm_mem_write=1, dm_address=0x0010, dm_write_data=0xBEEF; then empty=1.
REQ-029 SHALL cover: 4 back-to-back stores with continuous loads to 0x0050 -> count=4, st_ready=0; 5th st_valid forces drain, ld_ready=0 that cycle.
REQ-030 SHALL cover: stores 0x0020<-0x1111 then 0x0020<-0x2222, load 0x0020 -> FWD_EN: ld_data=0x2222 same cycle; no FWD_EN: ld_ready=0 for two drain cycles, then ld_data=0x2222 from memory.
REQ-031 SHALL cover: one store buffered, ld_valid held 10 cycles to 0x0030 -> seven grants, forced drain in cycle 8 (ld_ready=0), grants resume.
REQ-032 SHALL cover: wrap-around with 10 stores interleaved with drains -> memory writes in FIFO order, addresses 0x0000..0x0009.
REQ-033 SHALL cover: rst_n=0 with count=3 -> next cycle empty=1, st_ready=1, no dm_mem_write.
